// File: rtl/sobel_frame_sequencer.sv
// Frame sequencer between the UART RX byte stream, the sobel filter core and the UART TX:
// it validates the 4-byte header, forwards bytes, buffers filter output and reports frame status.
module sobel_frame_sequencer #(
  parameter int DATA_BITS      = 8,
  parameter int MAX_WIDTH      = 32,
  parameter int MAX_HEIGHT     = 1024,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_valid,
  output logic [DATA_BITS-1:0] flt_data,
  output logic                 flt_valid,
  output logic                 flt_rst,
  input  logic [DATA_BITS-1:0] flt_out_data,
  input  logic                 flt_out_valid,
  output logic                 flt_ready_out,
  output logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 err_hdr,
  output logic                 err_timeout,
  output logic                 err_overflow,
  output logic [15:0]          frame_count
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_STREAM, S_DRAIN, S_FLUSH, S_RECOVER} state_t;

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]   MAX_W    = 16'(MAX_WIDTH);
  localparam logic [15:0]   MAX_H    = 16'(MAX_HEIGHT);
  localparam logic [5:0]    REC_LAST = 6'd63;

  state_t               state, state_nxt;
  logic [2:0]           hdr_cnt;
  logic [15:0]          width, height;
  logic [31:0]          total, pix_in, pix_out;
  logic [IW-1:0]        idle_cnt;
  logic [5:0]           rec_cnt;
  logic                 flush_cnt;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;

  logic hdr_check, hdr_ok, rx_accept, timeout_hit, out_active;
  logic push, pop, full, wr_en, overflow, set_err_hdr, set_err_timeout;

  // The validation cycle follows the fourth header byte; an rx byte landing on it is dropped.
  assign hdr_check   = (state == S_HDR) && (hdr_cnt == 3'd4);
  assign hdr_ok      = (width >= 16'd3) && (width <= MAX_W) && (height >= 16'd3) && (height <= MAX_H);
  assign rx_accept   = rx_valid && ((state == S_IDLE) || (state == S_STREAM) ||
                                    ((state == S_HDR) && (hdr_cnt != 3'd4)));
  assign timeout_hit = !rx_valid && (idle_cnt >= IDLE_MAX);
  assign out_active  = (state == S_STREAM) || (state == S_DRAIN);

  assign push     = out_active && flt_out_valid;
  assign pop      = tx_valid && tx_ready;
  assign full     = (count == DEPTH_C);
  assign wr_en    = push && (!full || pop);
  assign overflow = push && full && !pop;

  // Two free entries leave room for the byte the filter may already have registered.
  assign flt_ready_out = out_active && ((DEPTH_C - count) >= CW'(2));
  assign flt_rst       = rst || (state == S_FLUSH) || (state == S_RECOVER);
  assign busy          = (state != S_IDLE);
  assign tx_valid      = (count != '0);
  assign tx_data       = mem[rd_ptr];

  // NOTE: every output of this block gets a default first so no path leaves a latch.
  always_comb begin
    state_nxt       = state;
    set_err_hdr     = 1'b0;
    set_err_timeout = 1'b0;
    unique case (state)
      S_IDLE:    if (rx_valid) state_nxt = S_HDR;
      S_HDR: begin
        if (hdr_check) begin
          if (hdr_ok) begin
            state_nxt = S_STREAM;
          end else begin
            state_nxt   = S_RECOVER;
            set_err_hdr = 1'b1;
          end
        end else if (timeout_hit) begin
          state_nxt       = S_RECOVER;
          set_err_timeout = 1'b1;
        end
      end
      S_STREAM: begin
        if (rx_valid && (pix_in + 32'd1 == total)) begin
          state_nxt = S_DRAIN;
        end else if (timeout_hit) begin
          state_nxt       = S_RECOVER;
          set_err_timeout = 1'b1;
        end
      end
      S_DRAIN:   if ((pix_out == total) && (count == '0)) state_nxt = S_FLUSH;
      S_FLUSH:   if (flush_cnt) state_nxt = S_IDLE;
      S_RECOVER: if (!rx_valid && (rec_cnt == REC_LAST)) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      hdr_cnt      <= '0;
      width        <= '0;
      height       <= '0;
      total        <= '0;
      pix_in       <= '0;
      pix_out      <= '0;
      idle_cnt     <= '0;
      rec_cnt      <= '0;
      flush_cnt    <= 1'b0;
      flt_data     <= '0;
      flt_valid    <= 1'b0;
      frame_done   <= 1'b0;
      frame_count  <= '0;
      err_hdr      <= 1'b0;
      err_timeout  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      state     <= state_nxt;
      flt_valid <= rx_accept;
      if (rx_accept) flt_data <= rx_data;

      if (rx_valid)                 idle_cnt <= '0;
      else if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + IW'(1);

      rec_cnt   <= ((state != S_RECOVER) || rx_valid) ? '0 : rec_cnt + 6'd1;
      flush_cnt <= (state == S_FLUSH) && !flush_cnt;

      frame_done <= (state == S_DRAIN) && (state_nxt == S_FLUSH);
      if ((state == S_DRAIN) && (state_nxt == S_FLUSH)) frame_count <= frame_count + 16'd1;

      if ((state == S_IDLE) && rx_valid) begin
        width[7:0]  <= rx_data[7:0];
        hdr_cnt     <= 3'd1;
        err_hdr     <= 1'b0;
        err_timeout <= 1'b0;
      end else if ((state == S_HDR) && rx_accept) begin
        hdr_cnt <= hdr_cnt + 3'd1;
        case (hdr_cnt)
          3'd1:    width[15:8]  <= rx_data[7:0];
          3'd2:    height[7:0]  <= rx_data[7:0];
          default: height[15:8] <= rx_data[7:0];
        endcase
      end

      if (set_err_hdr)     err_hdr      <= 1'b1;
      if (set_err_timeout) err_timeout  <= 1'b1;
      if (overflow)        err_overflow <= 1'b1;
      if (hdr_check)       total        <= 32'(width) * 32'(height);

      // Pixel counters restart after any frame end, completed or aborted.
      if ((state == S_FLUSH) || (state == S_RECOVER)) begin
        pix_in  <= '0;
        pix_out <= '0;
      end else begin
        if ((state == S_STREAM) && rx_valid) pix_in  <= pix_in + 32'd1;
        if (push)                            pix_out <= pix_out + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (state == S_RECOVER)) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; count gates tx_valid so stale entries are never presented.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= flt_out_data;
  end

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Scoreboard bench for sobel_frame_sequencer: random pixels and filter output bytes,
// expected forwarded/tx bytes queued at issue time and compared by a separate monitor.
module tb_sobel_frame_sequencer;
  localparam int DEPTH = 16;
  localparam int TMO   = 100;
  localparam int MAXW  = 32;
  localparam int MAXH  = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  flt_data;
  logic        flt_valid, flt_rst;
  logic [7:0]  flt_out_data;
  logic        flt_out_valid, flt_ready_out;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic        busy, frame_done, err_hdr, err_timeout, err_overflow;
  logic [15:0] frame_count;

  sobel_frame_sequencer #(
    .DATA_BITS(8), .MAX_WIDTH(MAXW), .MAX_HEIGHT(MAXH),
    .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .flt_data(flt_data), .flt_valid(flt_valid), .flt_rst(flt_rst),
    .flt_out_data(flt_out_data), .flt_out_valid(flt_out_valid), .flt_ready_out(flt_ready_out),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frame_done(frame_done),
    .err_hdr(err_hdr), .err_timeout(err_timeout), .err_overflow(err_overflow),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    int unsigned cyc;
  } fwd_t;

  fwd_t        fwd_q[$];
  logic [7:0]  exp_q[$];
  int          total_checks = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  int          fwd_seen = 0, tx_seen = 0, done_pulses = 0;
  int          rst_run = 0, last_run = 0;
  int          exp_drop = 0, out_left = 0, produced = 0, pix_sent = 0;
  int          exp_frames = 0;
  bit          inject = 1'b0, rand_tx = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops the scoreboards whenever the DUT presents a forwarded or transmitted byte.
  initial begin
    fwd_t f;
    forever begin
      @(negedge clk);
      if (flt_rst) rst_run++;
      else begin
        if (rst_run != 0) last_run = rst_run;
        rst_run = 0;
      end
      if (!rst) begin
        if (frame_done) done_pulses++;
        if (flt_valid) begin
          fwd_seen++;
          check("fwd_expected", 32'(fwd_q.size() != 0), 1);
          if (fwd_q.size() != 0) begin
            f = fwd_q.pop_front();
            check("fwd_data", 32'(flt_data), 32'(f.data));
            check("fwd_latency", cyc - f.cyc, 1);
          end
        end
        if (tx_valid && tx_ready) begin
          tx_seen++;
          check("tx_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // Filter stand-in: one output per received pixel, honouring ready unless injecting.
  initial begin
    logic [7:0] b;
    flt_out_valid = 1'b0;
    flt_out_data  = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      flt_out_valid = 1'b0;
      if (out_left > 0 && produced < pix_sent && (inject || flt_ready_out)) begin
        b             = 8'($urandom);
        flt_out_data  = b;
        flt_out_valid = 1'b1;
        out_left--;
        produced++;
        if (exp_q.size() == DEPTH && !tx_ready) exp_drop++;
        else exp_q.push_back(b);
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_tx) tx_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total_checks, bad);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit fwd);
    rx_data  = b;
    rx_valid = 1'b1;
    if (fwd) fwd_q.push_back('{data: b, cyc: cyc});
    tick(1);
    rx_valid = 1'b0;
    tick(int'($urandom_range(1, 3)));
  endtask

  function automatic bit hdr_valid(input int w, input int h);
    return (w >= 3) && (w <= MAXW) && (h >= 3) && (h <= MAXH);
  endfunction

  task automatic start_frame(input int w, input int h);
    produced = 0;
    pix_sent = 0;
    out_left = hdr_valid(w, h) ? w * h : 0;
    send_byte(8'(w), 1);
    send_byte(8'(w >> 8), 1);
    send_byte(8'(h), 1);
    send_byte(8'(h >> 8), 1);
  endtask

  task automatic send_pixels(input int n);
    for (int i = 0; i < n; i++) begin
      send_byte(8'($urandom), 1);
      pix_sent++;
    end
  endtask

  task automatic wait_idle(input string name, input int limit, output int n);
    n = 0;
    while (busy && n < limit) begin
      tick(1);
      n++;
    end
    check({name, "_idle"}, 32'(busy), 0);
    tick(2);
  endtask

  initial begin
    int n, d0, t0, f0, w, h;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    tick(3);
    check("rst_flt_rst", 32'(flt_rst), 1);
    check("rst_outputs", {flt_valid, flt_ready_out, tx_valid, busy, frame_done,
                          err_hdr, err_timeout, err_overflow}, 0);
    check("rst_frame_count", 32'(frame_count), 0);
    rst = 1'b0;
    tick(2);
    check("idle_flt_rst", 32'(flt_rst), 0);

    // Nominal 5x4 frame with TX always ready.
    tx_ready = 1'b1;
    d0 = done_pulses; t0 = tx_seen; f0 = fwd_seen;
    start_frame(5, 4);
    send_pixels(20);
    wait_idle("t1", 300, n);
    exp_frames++;
    check("t1_fwd_count", fwd_seen - f0, 24);
    check("t1_tx_count", tx_seen - t0, 20);
    check("t1_done_pulses", done_pulses - d0, 1);
    check("t1_frame_count", 32'(frame_count), exp_frames);
    check("t1_flush_len", last_run, 2);

    // Width 64 exceeds the line buffer.
    start_frame(64, 4);
    tick(2);
    check("t2_err_hdr", 32'(err_hdr), 1);
    check("t2_busy", 32'(busy), 1);
    check("t2_flt_rst", 32'(flt_rst), 1);
    wait_idle("t2", 200, n);
    check("t2_recover_min", 32'(n >= 60), 1);
    check("t2_frame_count", 32'(frame_count), exp_frames);
    check("t2_err_hdr_sticky", 32'(err_hdr), 1);

    // 4x4 with TX stalled: backpressure must stop the filter one short of full.
    tx_ready = 1'b0;
    d0 = done_pulses; t0 = tx_seen;
    start_frame(4, 4);
    check("t3_err_hdr_clear", 32'(err_hdr), 0);
    send_pixels(16);
    tick(10);
    check("t3_ready_low", 32'(flt_ready_out), 0);
    check("t3_fill", exp_q.size(), DEPTH - 1);
    check("t3_no_overflow", 32'(err_overflow), 0);
    tx_ready = 1'b1;
    wait_idle("t3", 300, n);
    exp_frames++;
    check("t3_tx_count", tx_seen - t0, 16);
    check("t3_done_pulses", done_pulses - d0, 1);

    // 5x5 with ready ignored and TX stalled: 9 outputs land on a full FIFO.
    tx_ready = 1'b0; inject = 1'b1; exp_drop = 0;
    t0 = tx_seen;
    start_frame(5, 5);
    send_pixels(25);
    tick(10);
    check("t4_err_overflow", 32'(err_overflow), 1);
    check("t4_dropped", exp_drop, 9);
    inject = 1'b0; tx_ready = 1'b1;
    wait_idle("t4", 300, n);
    exp_frames++;
    check("t4_tx_count", tx_seen - t0, 16);
    check("t4_frame_count", 32'(frame_count), exp_frames);

    // RX goes silent after 3 of 9 pixels.
    start_frame(3, 3);
    send_pixels(3);
    tick(85);
    check("t5_no_early_timeout", 32'(err_timeout), 0);
    n = 0;
    while (!err_timeout && n < 40) begin
      tick(1);
      n++;
    end
    check("t5_err_timeout", 32'(err_timeout), 1);
    check("t5_flt_rst", 32'(flt_rst), 1);
    out_left = 0;
    wait_idle("t5_recover", 200, n);
    check("t5_frame_count", 32'(frame_count), exp_frames);
    start_frame(3, 3);
    check("t5_err_timeout_clear", 32'(err_timeout), 0);
    send_pixels(9);
    wait_idle("t5_frame", 300, n);
    exp_frames++;
    check("t5_frame_count_after", 32'(frame_count), exp_frames);

    // Back-to-back 3x3 frames; a 4-byte tail after the first must never reach the filter.
    tx_ready = 1'b0;
    start_frame(3, 3);
    send_pixels(9);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
    tx_ready = 1'b1;
    wait_idle("t6_a", 300, n);
    start_frame(3, 3);
    send_pixels(9);
    wait_idle("t6_b", 300, n);
    exp_frames += 2;
    check("t6_frame_count", 32'(frame_count), exp_frames);
    check("t6_fwd_drained", fwd_q.size(), 0);

    // Random frames, some with invalid headers, with random TX backpressure.
    rand_tx = 1'b1;
    for (int k = 0; k < 6; k++) begin
      w = int'($urandom_range(2, 36));
      h = ($urandom_range(0, 4) == 0) ? 1025 : int'($urandom_range(3, 5));
      start_frame(w, h);
      if (hdr_valid(w, h)) begin
        send_pixels(w * h);
        wait_idle("rnd_frame", 3000, n);
        exp_frames++;
        check("rnd_err_hdr", 32'(err_hdr), 0);
      end else begin
        tick(2);
        check("rnd_err_hdr", 32'(err_hdr), 1);
        wait_idle("rnd_recover", 300, n);
      end
      check("rnd_frame_count", 32'(frame_count), exp_frames);
    end
    rand_tx = 1'b0;
    tx_ready = 1'b1;
    tick(5);
    check("rnd_tx_drained", exp_q.size(), 0);

    // Reset in the middle of a frame.
    start_frame(3, 3);
    send_pixels(2);
    tick(3);
    rst = 1'b1;
    tick(1);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_flt_rst", 32'(flt_rst), 1);
    check("mid_rst_flags", {tx_valid, flt_valid, err_overflow, err_hdr, err_timeout}, 0);
    check("mid_rst_frame_count", 32'(frame_count), 0);
    rst = 1'b0;
    out_left = 0;
    exp_q.delete();
    fwd_q.delete();
    exp_frames = 0;
    tick(2);
    start_frame(3, 3);
    send_pixels(9);
    wait_idle("post_rst", 300, n);
    exp_frames++;
    check("post_rst_frame_count", 32'(frame_count), exp_frames);

    $display("test done: total=%0d bad=%0d", total_checks, bad);
    $finish;
  end

endmodule
